// File: rtl/eh2_lsu_ecc_scrub.sv
// DCCM ECC correction queue and background scrubber for the EH2 LSU.
// Load-pipe and scrub corrections are queued and retired as lowest-priority DCCM writes.
module eh2_lsu_ecc_scrub #(
    parameter int          NUM_BANKS  = 2,
    parameter int          DATA_WIDTH = 32,
    parameter int          ECC_WIDTH  = 7,
    parameter int          ADDR_WIDTH = 16,
    parameter int          DEPTH      = 4,
    parameter int unsigned SCRUB_LAST = 16'hFFFF,
    parameter int          INTERVAL   = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_BANKS-1:0]              det_valid,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0]   det_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]   det_data,
    input  logic                              st_wr_valid,
    input  logic [ADDR_WIDTH-1:0]             st_wr_addr,
    output logic                              wr_valid,
    output logic [ADDR_WIDTH-1:0]             wr_addr,
    output logic [DATA_WIDTH+ECC_WIDTH-1:0]   wr_data,
    input  logic                              wr_ready,
    input  logic                              scrub_en,
    output logic                              rd_valid,
    output logic [ADDR_WIDTH-1:0]             rd_addr,
    input  logic                              rd_ready,
    input  logic                              rd_resp_valid,
    input  logic [DATA_WIDTH+ECC_WIDTH-1:0]   rd_resp_data,
    output logic [15:0]                       sec_count,
    output logic [15:0]                       ded_count,
    output logic [7:0]                        drop_count,
    output logic                              ded_pulse
);

    localparam int CWW  = DATA_WIDTH + ECC_WIDTH;
    localparam int NREQ = NUM_BANKS + 1;
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int IVW  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_t;

    function automatic logic is_pow2(input int unsigned p);
        return (p & (p - 1)) == 0;
    endfunction

    // Codeword positions are 1-based with powers of two reserved for check bits.
    function automatic int unsigned next_data_pos(input int unsigned p);
        int unsigned n;
        n = p + 1;
        if (is_pow2(n)) n = n + 1;
        if (is_pow2(n)) n = n + 1;
        return n;
    endfunction

    function automatic logic [ECC_WIDTH-2:0] ecc_checks(input logic [DATA_WIDTH-1:0] d);
        logic [ECC_WIDTH-2:0] c;
        int unsigned          pos;
        c   = '0;
        pos = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = next_data_pos(pos);
            for (int j = 0; j < ECC_WIDTH - 1; j++) begin
                if (pos[j]) c[j] = c[j] ^ d[i];
            end
        end
        return c;
    endfunction

    function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
        logic [ECC_WIDTH-2:0] c;
        c = ecc_checks(d);
        return {^{d, c}, c};
    endfunction

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   scrub_addr;
    logic [IVW-1:0]          ivl_cnt;
    logic                    ivl_done;
    logic                    scrub_fire, scrub_single, scrub_double;

    logic [DATA_WIDTH-1:0]   resp_data, resp_fixed;
    logic [ECC_WIDTH-1:0]    resp_ecc;
    logic [ECC_WIDTH-2:0]    syn;
    logic                    resp_parity_err;

    logic [ADDR_WIDTH-1:0]   q_addr   [DEPTH];
    logic [DATA_WIDTH-1:0]   q_data   [DEPTH];
    logic [ADDR_WIDTH-1:0]   q_addr_n [DEPTH];
    logic [DATA_WIDTH-1:0]   q_data_n [DEPTH];
    logic [DEPTH-1:0]        q_vld, q_vld_n;
    logic [PTRW-1:0]         head, head_inc, slot;
    logic [CNTW-1:0]         count, count_n;
    logic                    q_full, head_hit, head_ok, pop;
    int                      free, n_push, n_drop, n_sec;

    logic [NREQ-1:0]         req_v;
    logic [ADDR_WIDTH-1:0]   req_a [NREQ];
    logic [DATA_WIDTH-1:0]   req_d [NREQ];

    logic [16:0]             sec_sum;
    logic [8:0]              drop_sum;

    // Scrub response decode: the overall parity bit distinguishes single from double errors.
    assign resp_data       = rd_resp_data[DATA_WIDTH-1:0];
    assign resp_ecc        = rd_resp_data[CWW-1:DATA_WIDTH];
    assign syn             = resp_ecc[ECC_WIDTH-2:0] ^ ecc_checks(resp_data);
    assign resp_parity_err = ^rd_resp_data;

    always_comb begin
        int unsigned pos;
        resp_fixed = resp_data;
        pos        = 0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = next_data_pos(pos);
            if (resp_parity_err && (syn == pos[ECC_WIDTH-2:0])) resp_fixed[i] = ~resp_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (scrub_en) state_nxt = S_WAIT;
            S_WAIT: begin
                if (!scrub_en)                  state_nxt = S_IDLE;
                else if (ivl_done && !q_full)   state_nxt = S_READ;
            end
            S_READ: if (rd_ready) state_nxt = S_RESP;
            S_RESP: if (rd_resp_valid) state_nxt = scrub_en ? S_WAIT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_valid   = 1'b0;
        scrub_fire = 1'b0;
        case (state)
            S_READ:  rd_valid   = 1'b1;
            S_RESP:  scrub_fire = rd_resp_valid;
            default: ;
        endcase
    end

    assign rd_addr      = scrub_addr;
    assign ivl_done     = (ivl_cnt == IVW'(INTERVAL - 1));
    assign scrub_single = scrub_fire && resp_parity_err;
    assign scrub_double = scrub_fire && (syn != '0) && !resp_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_addr <= '0;
            ivl_cnt    <= '0;
        end else begin
            if (state != S_WAIT)  ivl_cnt <= '0;
            else if (!ivl_done)   ivl_cnt <= ivl_cnt + 1'b1;
            if (scrub_fire)
                scrub_addr <= (scrub_addr == ADDR_WIDTH'(SCRUB_LAST)) ? '0 : scrub_addr + 1'b1;
        end
    end

    // Bank requests first in index order, scrub correction last.
    always_comb begin
        for (int r = 0; r < NUM_BANKS; r++) begin
            req_v[r] = det_valid[r];
            req_a[r] = det_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
            req_d[r] = det_data[r*DATA_WIDTH +: DATA_WIDTH];
        end
        req_v[NUM_BANKS] = scrub_single;
        req_a[NUM_BANKS] = scrub_addr;
        req_d[NUM_BANKS] = resp_fixed;
    end

    // A head hit by a store this cycle is dropped silently and popped without a write.
    assign q_full   = (count == CNTW'(DEPTH));
    assign head_hit = st_wr_valid && (q_addr[head] == st_wr_addr);
    assign head_ok  = (count != '0) && q_vld[head] && !head_hit;
    assign pop      = (count != '0) && (!head_ok || wr_ready);
    assign free     = DEPTH - int'(count) + int'(pop);
    assign head_inc = PTRW'((int'(head) + 1) % DEPTH);
    assign count_n  = CNTW'(int'(count) - int'(pop) + n_push);

    assign wr_valid = head_ok;
    assign wr_addr  = head_ok ? q_addr[head] : '0;
    assign wr_data  = head_ok ? {ecc_encode(q_data[head]), q_data[head]} : '0;

    always_comb begin
        q_addr_n = q_addr;
        q_data_n = q_data;
        q_vld_n  = q_vld;
        n_push   = 0;
        n_drop   = 0;
        n_sec    = 0;
        slot     = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (st_wr_valid && (q_addr[e] == st_wr_addr)) q_vld_n[e] = 1'b0;
        end
        if (pop) q_vld_n[head] = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (req_v[r]) begin
                n_sec = n_sec + 1;
                if (!(st_wr_valid && (req_a[r] == st_wr_addr))) begin
                    if (n_push < free) begin
                        slot           = PTRW'((int'(head) + int'(count) + n_push) % DEPTH);
                        q_addr_n[slot] = req_a[r];
                        q_data_n[slot] = req_d[r];
                        q_vld_n[slot]  = 1'b1;
                        n_push         = n_push + 1;
                    end else begin
                        n_drop = n_drop + 1;
                    end
                end
            end
        end
    end

    assign sec_sum  = {1'b0, sec_count} + 17'(n_sec);
    assign drop_sum = {1'b0, drop_count} + 9'(n_drop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            count      <= '0;
            q_vld      <= '0;
            sec_count  <= '0;
            ded_count  <= '0;
            drop_count <= '0;
            ded_pulse  <= 1'b0;
        end else begin
            head       <= pop ? head_inc : head;
            count      <= count_n;
            q_vld      <= q_vld_n;
            sec_count  <= sec_sum[16] ? 16'hFFFF : sec_sum[15:0];
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (scrub_double && (ded_count != 16'hFFFF)) ded_count <= ded_count + 16'd1;
            ded_pulse  <= scrub_double;
        end
    end

    always_ff @(posedge clk) begin
        q_addr <= q_addr_n;
        q_data <= q_data_n;
    end

endmodule

// File: tb/tb_eh2_lsu_ecc_scrub.sv
// Directed bench for eh2_lsu_ecc_scrub: table of queue/hazard vectors plus scrub sequences.
module tb_eh2_lsu_ecc_scrub;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  det_valid;
    logic [31:0] det_addr;
    logic [63:0] det_data;
    logic        st_wr_valid;
    logic [15:0] st_wr_addr;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [38:0] wr_data;
    logic        wr_ready;
    logic        scrub_en;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic        rd_ready;
    logic        rd_resp_valid;
    logic [38:0] rd_resp_data;
    logic [15:0] sec_count;
    logic [15:0] ded_count;
    logic [7:0]  drop_count;
    logic        ded_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  dv;
        logic [15:0] a0;
        logic [31:0] d0;
        logic [15:0] a1;
        logic [31:0] d1;
        logic        st;
        logic [15:0] sa;
        logic        rdy;
        logic        ev;
        logic [15:0] ea;
        logic [38:0] ewd;
        logic [15:0] esec;
        logic [7:0]  edrop;
    } vec_t;

    vec_t vt[$];

    eh2_lsu_ecc_scrub #(
        .NUM_BANKS(2), .DATA_WIDTH(32), .ECC_WIDTH(7), .ADDR_WIDTH(16),
        .DEPTH(4), .SCRUB_LAST(3), .INTERVAL(4)
    ) dut (
        .clk(clk), .rst(rst),
        .det_valid(det_valid), .det_addr(det_addr), .det_data(det_data),
        .st_wr_valid(st_wr_valid), .st_wr_addr(st_wr_addr),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .scrub_en(scrub_en), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .sec_count(sec_count), .ded_count(ded_count), .drop_count(drop_count),
        .ded_pulse(ded_pulse)
    );

    always #5 clk = ~clk;

    // Reference encoder builds the whole 38-position codeword explicitly.
    function automatic logic [6:0] ref_ecc(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  e;
        int          k;
        cw = '0;
        e  = '0;
        k  = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 6; j++)
            for (int p = 1; p <= 38; p++)
                if (((p >> j) & 1) == 1) e[j] = e[j] ^ cw[p];
        e[6] = (^cw) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic logic [38:0] ref_cw(input logic [31:0] d);
        return {ref_ecc(d), d};
    endfunction

    task automatic add_vec(input logic [1:0] dv, input logic [15:0] a0, input logic [31:0] d0,
                           input logic [15:0] a1, input logic [31:0] d1,
                           input logic st, input logic [15:0] sa, input logic rdy,
                           input logic ev, input logic [15:0] ea, input logic [31:0] ed,
                           input logic [15:0] esec, input logic [7:0] edrop);
        vec_t v;
        v.dv = dv; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.st = st; v.sa = sa; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ewd = ref_cw(ed); v.esec = esec; v.edrop = edrop;
        vt.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        det_valid   = v.dv;
        det_addr    = {v.a1, v.a0};
        det_data    = {v.d1, v.d0};
        st_wr_valid = v.st;
        st_wr_addr  = v.sa;
        wr_ready    = v.rdy;
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, " wr_valid"},   wr_valid,   0);
        checkOutput({tag, " rd_valid"},   rd_valid,   0);
        checkOutput({tag, " sec_count"},  sec_count,  0);
        checkOutput({tag, " ded_count"},  ded_count,  0);
        checkOutput({tag, " drop_count"}, drop_count, 0);
        checkOutput({tag, " ded_pulse"},  ded_pulse,  0);
    endtask

    task automatic wait_rd(input logic [15:0] exp_addr);
        int n;
        n = 0;
        @(negedge clk);
        while (!rd_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rd_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL rd_valid timeout: got 0 expected 1 (addr %0h)", exp_addr);
        end else begin
            checkOutput("rd_addr", rd_addr, exp_addr);
        end
    endtask

    // Accept edge, then one response cycle, then sample at the following negedge.
    task automatic scrub_respond(input logic [38:0] cw);
        @(posedge clk); #1;
        rd_resp_valid = 1'b1;
        rd_resp_data  = cw;
        @(posedge clk); #1;
        rd_resp_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] d0, d1, d2, d3;

        rst = 1'b1; det_valid = '0; det_addr = '0; det_data = '0;
        st_wr_valid = 1'b0; st_wr_addr = '0; wr_ready = 1'b0; scrub_en = 1'b0;
        rd_ready = 1'b0; rd_resp_valid = 1'b0; rd_resp_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        //       dv     a0       d0            a1       d1            st    sa       rdy   ev    ea       ed            sec  drop
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        0,   0);
        add_vec(2'b01, 16'h10,  32'hDEADBEEF, 16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        0,   0);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h10,  32'hDEADBEEF, 1,   0);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        1,   0);
        add_vec(2'b10, 16'h0,   32'h0,        16'h30,  32'h1,        1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   32'h0,        1,   0);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b0, 1'b1, 16'h30,  32'h1,        2,   0);
        vt[vt.size()-1].ewd = 39'h43_0000_0001;
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h30,  32'h1,        2,   0);
        add_vec(2'b11, 16'h100, 32'hCAFE0100, 16'h101, 32'hCAFE0101, 1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   32'h0,        2,   0);
        add_vec(2'b11, 16'h102, 32'hCAFE0102, 16'h103, 32'hCAFE0103, 1'b0, 16'h0,   1'b0, 1'b1, 16'h100, 32'hCAFE0100, 4,   0);
        add_vec(2'b11, 16'h104, 32'hCAFE0104, 16'h105, 32'hCAFE0105, 1'b0, 16'h0,   1'b0, 1'b1, 16'h100, 32'hCAFE0100, 6,   0);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b0, 1'b1, 16'h100, 32'hCAFE0100, 8,   2);
        add_vec(2'b11, 16'h106, 32'hCAFE0106, 16'h107, 32'hCAFE0107, 1'b0, 16'h0,   1'b1, 1'b1, 16'h100, 32'hCAFE0100, 8,   2);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h101, 32'hCAFE0101, 10,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h102, 32'hCAFE0102, 10,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h103, 32'hCAFE0103, 10,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h106, 32'hCAFE0106, 10,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        10,  3);
        add_vec(2'b01, 16'h20,  32'h11111111, 16'h0,   32'h0,        1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   32'h0,        10,  3);
        add_vec(2'b01, 16'h21,  32'h22222222, 16'h0,   32'h0,        1'b0, 16'h0,   1'b0, 1'b1, 16'h20,  32'h11111111, 11,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b1, 16'h20,  1'b1, 1'b0, 16'h0,   32'h0,        12,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h21,  32'h22222222, 12,  3);
        add_vec(2'b01, 16'h40,  32'h33333333, 16'h0,   32'h0,        1'b1, 16'h40,  1'b1, 1'b0, 16'h0,   32'h0,        12,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        13,  3);
        add_vec(2'b11, 16'h50,  32'h44444444, 16'h51,  32'h55555555, 1'b0, 16'h0,   1'b0, 1'b0, 16'h0,   32'h0,        13,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b1, 16'h51,  1'b0, 1'b1, 16'h50,  32'h44444444, 15,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b1, 16'h50,  32'h44444444, 15,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        15,  3);
        add_vec(2'b00, 16'h0,   32'h0,        16'h0,   32'h0,        1'b0, 16'h0,   1'b1, 1'b0, 16'h0,   32'h0,        15,  3);

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk); #1;
            applyStimulus(vt[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d wr_valid", i), wr_valid, vt[i].ev);
            if (vt[i].ev) begin
                checkOutput($sformatf("v%0d wr_addr", i), wr_addr, vt[i].ea);
                checkOutput($sformatf("v%0d wr_data", i), wr_data, vt[i].ewd);
            end
            checkOutput($sformatf("v%0d sec_count", i),  sec_count,  vt[i].esec);
            checkOutput($sformatf("v%0d drop_count", i), drop_count, vt[i].edrop);
        end

        @(posedge clk); #1;
        det_valid = '0; st_wr_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("rereset");
        @(posedge clk); #1;
        rst = 1'b0; scrub_en = 1'b1; rd_ready = 1'b1; wr_ready = 1'b1;

        d0 = 32'h00005A5A; d1 = 32'h12345678; d2 = 32'h0F0F0F0F; d3 = 32'h89ABCDEF;

        wait_rd(16'h0);
        scrub_respond(ref_cw(d0) ^ (39'b1 << 5));
        checkOutput("scrub0 wr_valid",  wr_valid,  1);
        checkOutput("scrub0 wr_addr",   wr_addr,   16'h0);
        checkOutput("scrub0 wr_data",   wr_data,   ref_cw(d0));
        checkOutput("scrub0 sec_count", sec_count, 1);
        checkOutput("scrub0 ded_pulse", ded_pulse, 0);

        wait_rd(16'h1);
        scrub_respond(ref_cw(d1) ^ (39'b1 << 3) ^ (39'b1 << 17));
        checkOutput("scrub1 ded_pulse", ded_pulse, 1);
        checkOutput("scrub1 ded_count", ded_count, 1);
        checkOutput("scrub1 wr_valid",  wr_valid,  0);
        checkOutput("scrub1 sec_count", sec_count, 1);
        @(negedge clk);
        checkOutput("scrub1 ded_pulse width", ded_pulse, 0);

        wait_rd(16'h2);
        scrub_respond(ref_cw(d2) ^ (39'b1 << 38));
        checkOutput("scrub2 wr_valid",  wr_valid,  1);
        checkOutput("scrub2 wr_addr",   wr_addr,   16'h2);
        checkOutput("scrub2 wr_data",   wr_data,   ref_cw(d2));
        checkOutput("scrub2 sec_count", sec_count, 2);

        wait_rd(16'h3);
        scrub_respond(ref_cw(d3));
        checkOutput("scrub3 wr_valid",  wr_valid,  0);
        checkOutput("scrub3 sec_count", sec_count, 2);

        wait_rd(16'h0);
        scrub_respond(ref_cw(d0));
        checkOutput("wrap wr_valid",  wr_valid,  0);
        checkOutput("wrap ded_count", ded_count, 1);

        // Reset lands while a read is outstanding and a correction sits in the queue.
        wait_rd(16'h1);
        @(posedge clk); #1;
        wr_ready  = 1'b0;
        det_valid = 2'b01;
        det_addr  = {16'h0, 16'h77};
        det_data  = {32'h0, 32'h00000077};
        @(posedge clk); #1;
        det_valid = '0;
        rst       = 1'b1;
        scrub_en  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst           = 1'b0;
        rd_resp_valid = 1'b1;
        rd_resp_data  = ref_cw(d1) ^ (39'b1 << 9);
        @(posedge clk); #1;
        rd_resp_valid = 1'b0;
        @(negedge clk);
        check_reset_state("late resp");
        repeat (3) @(negedge clk);
        checkOutput("idle rd_valid", rd_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
